ucie_ctl_tx_sync_fifo: RTL and testbench



---
 rtl/ucie_ctl_fifo_pkg.sv | 14 +
 rtl/ucie_ctl_fifo_ptr.sv | 30 +++
 rtl/ucie_ctl_tx_sync_fifo.sv | 96 +++++++++
 tb/tb_ucie_ctl_tx_sync_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_fifo_pkg.sv
// Shared defaults and helpers for the UCIe controller single-clock FIFO.
package ucie_ctl_fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 16;

    // Pointer width for an n-entry array; a 1-entry index still needs one bit.
    function automatic int clog2_min1(input int n);
        int c;
        c = $clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/ucie_ctl_fifo_ptr.sv
// Wrapping index register: counts 0..DEPTH-1 and wraps explicitly, so any depth works.
module ucie_ctl_fifo_ptr
    import ucie_ctl_fifo_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH_DEF,
    localparam int PTR_W = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Pointer register; reset beats clear, clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= {PTR_W{1'b0}};
        end else if (clr) begin
            ptr <= {PTR_W{1'b0}};
        end else if (inc) begin
            ptr <= (ptr == LAST) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/ucie_ctl_tx_sync_fifo.sv
// Single-clock show-ahead FIFO between the FDI-side producer and the RDI-side consumer.
// Full/empty come from the occupancy counter, never from pointer comparison.
module ucie_ctl_tx_sync_fifo
    import ucie_ctl_fifo_pkg::*;
#(
    parameter int  DATA_W = FIFO_DATA_W_DEF,
    parameter int  DEPTH  = FIFO_DEPTH_DEF,
    parameter int  AF_LVL = DEPTH - 2,
    parameter int  AE_LVL = 2,
    localparam int PTR_W  = clog2_min1(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LVL);

    if (DEPTH < 2) begin : g_bad_depth
        $error("ucie_ctl_tx_sync_fifo: DEPTH must be >= 2");
    end
    if ((AF_LVL < 1) || (AF_LVL > DEPTH)) begin : g_bad_af
        $error("ucie_ctl_tx_sync_fifo: AF_LVL must be in 1..DEPTH");
    end
    if ((AE_LVL < 0) || (AE_LVL >= DEPTH)) begin : g_bad_ae
        $error("ucie_ctl_tx_sync_fifo: AE_LVL must be in 0..DEPTH-1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_r;
    logic              push;
    logic              pop;

    // in_ready ignores out_ready on purpose: a full FIFO never push-and-pops in one cycle.
    assign in_ready     = (count_r != FULL_CNT);
    assign out_valid    = (count_r != {CNT_W{1'b0}});
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;
    assign out_data     = mem[rd_ptr];
    assign count        = count_r;
    assign almost_full  = (count_r >= AF_CNT);
    assign almost_empty = (count_r <= AE_CNT);

    ucie_ctl_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    ucie_ctl_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Storage array; no reset, a write dropped by rst/flush leaves the entry untouched.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Occupancy counter; push and pop together leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_ucie_ctl_tx_sync_fifo.sv
// Self-checking bench: directed vector table on a DEPTH=5 FIFO, then randomized
// traffic on DEPTH=16 and DEPTH=7 FIFOs against queue models.
module tb_ucie_ctl_tx_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) begin
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- directed DUT: DEPTH=5, AF=3, AE=2 ----------------
    logic       rst5, fl5, iv5, ir5, ov5, or5, af5, ae5;
    logic [7:0] d5, od5;
    logic [2:0] cnt5;

    ucie_ctl_tx_sync_fifo #(.DATA_W(8), .DEPTH(5), .AF_LVL(3), .AE_LVL(2)) u_d5 (
        .clk          (clk),
        .rst          (rst5),
        .flush        (fl5),
        .in_valid     (iv5),
        .in_ready     (ir5),
        .in_data      (d5),
        .out_valid    (ov5),
        .out_ready    (or5),
        .out_data     (od5),
        .count        (cnt5),
        .almost_full  (af5),
        .almost_empty (ae5)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic [2:0] cnt;
        logic       ov;
        logic       ir;
        logic       af;
        logic       ae;
        logic       cd;
        logic [7:0] od;
    } vec_t;

    function automatic vec_t mkv(input logic iv, input logic [7:0] d, input logic ordy,
                                 input logic fl, input int cnt, input logic ov, input logic ir,
                                 input logic af, input logic ae, input logic cd,
                                 input logic [7:0] od);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.cnt = 3'(cnt);
        v.ov = ov; v.ir = ir; v.af = af; v.ae = ae; v.cd = cd; v.od = od;
        return v;
    endfunction

    // ---------------- random DUTs: DEPTH=16 and DEPTH=7 ----------------
    logic       rrst, rfl;
    logic       riv [2];
    logic [7:0] rdi [2];
    logic       rord[2];
    logic       rir [2];
    logic       rov [2];
    logic       raf [2];
    logic       rae [2];
    logic [7:0] rdo [2];
    logic [4:0] rcnt[2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
        localparam int D  = (gi == 0) ? 16 : 7;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] c;
        logic          ir, ov, af, ae;
        logic [7:0]    dout;

        ucie_ctl_tx_sync_fifo #(.DATA_W(8), .DEPTH(D)) u_dut (
            .clk          (clk),
            .rst          (rrst),
            .flush        (rfl),
            .in_valid     (riv[gi]),
            .in_ready     (ir),
            .in_data      (rdi[gi]),
            .out_valid    (ov),
            .out_ready    (rord[gi]),
            .out_data     (dout),
            .count        (c),
            .almost_full  (af),
            .almost_empty (ae)
        );

        assign rcnt[gi] = 5'(c);
        assign rir[gi]  = ir;
        assign rov[gi]  = ov;
        assign raf[gi]  = af;
        assign rae[gi]  = ae;
        assign rdo[gi]  = dout;
    end

    initial begin
        vec_t       tbl[$];
        logic [7:0] mq[2][$];
        bit         hold[2];
        bit         push_m[2];
        bit         pop_m[2];
        int         dep[2];
        int         sz;

        dep[0] = 16;
        dep[1] = 7;

        //            iv  d      or  fl cnt ov ir af ae cd od
        tbl.push_back(mkv(1, 8'h11, 0, 0, 1, 1, 1, 0, 1, 1, 8'h11));
        tbl.push_back(mkv(1, 8'h12, 0, 0, 2, 1, 1, 0, 1, 1, 8'h11));
        tbl.push_back(mkv(1, 8'h13, 0, 0, 3, 1, 1, 1, 0, 1, 8'h11));
        tbl.push_back(mkv(1, 8'h14, 0, 0, 4, 1, 1, 1, 0, 1, 8'h11));
        tbl.push_back(mkv(1, 8'h15, 0, 0, 5, 1, 0, 1, 0, 1, 8'h11));
        tbl.push_back(mkv(1, 8'h16, 0, 0, 5, 1, 0, 1, 0, 1, 8'h11));
        tbl.push_back(mkv(1, 8'h16, 1, 0, 4, 1, 1, 1, 0, 1, 8'h12));
        tbl.push_back(mkv(1, 8'h16, 0, 0, 5, 1, 0, 1, 0, 1, 8'h12));
        tbl.push_back(mkv(0, 8'h00, 1, 0, 4, 1, 1, 1, 0, 1, 8'h13));
        tbl.push_back(mkv(0, 8'h00, 1, 0, 3, 1, 1, 1, 0, 1, 8'h14));
        tbl.push_back(mkv(0, 8'h00, 1, 0, 2, 1, 1, 0, 1, 1, 8'h15));
        tbl.push_back(mkv(0, 8'h00, 1, 0, 1, 1, 1, 0, 1, 1, 8'h16));
        tbl.push_back(mkv(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mkv(1, 8'h21, 0, 0, 1, 1, 1, 0, 1, 1, 8'h21));
        tbl.push_back(mkv(1, 8'h22, 0, 0, 2, 1, 1, 0, 1, 1, 8'h21));
        tbl.push_back(mkv(1, 8'h23, 0, 0, 3, 1, 1, 1, 0, 1, 8'h21));
        tbl.push_back(mkv(1, 8'h24, 1, 1, 0, 0, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mkv(1, 8'hAB, 0, 0, 1, 1, 1, 0, 1, 1, 8'hAB));
        tbl.push_back(mkv(0, 8'h00, 0, 0, 1, 1, 1, 0, 1, 1, 8'hAB));
        tbl.push_back(mkv(1, 8'hCD, 1, 0, 1, 1, 1, 0, 1, 1, 8'hCD));

        rst5 = 1'b1; fl5 = 1'b0; iv5 = 1'b0; d5 = 8'h00; or5 = 1'b0;
        rrst = 1'b1; rfl = 1'b0;
        for (int k = 0; k < 2; k++) begin
            riv[k] = 1'b0; rdi[k] = 8'h00; rord[k] = 1'b0; hold[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst5 = 1'b0;

        check("reset_count",     32'(cnt5), 32'd0);
        check("reset_out_valid", 32'(ov5),  32'd0);
        check("reset_in_ready",  32'(ir5),  32'd1);
        check("reset_ae",        32'(ae5),  32'd1);
        check("reset_af",        32'(af5),  32'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            iv5 = tbl[i].iv; d5 = tbl[i].d; or5 = tbl[i].ordy; fl5 = tbl[i].fl;
            @(posedge clk);
            #1;
            check($sformatf("row%0d_count", i),     32'(cnt5), 32'(tbl[i].cnt));
            check($sformatf("row%0d_out_valid", i), 32'(ov5),  32'(tbl[i].ov));
            check($sformatf("row%0d_in_ready", i),  32'(ir5),  32'(tbl[i].ir));
            check($sformatf("row%0d_af", i),        32'(af5),  32'(tbl[i].af));
            check($sformatf("row%0d_ae", i),        32'(ae5),  32'(tbl[i].ae));
            if (tbl[i].cd) begin
                check($sformatf("row%0d_data", i),  32'(od5),  32'(tbl[i].od));
            end
        end

        // Steady push+pop at count 1 for 23 cycles: pointers wrap several times.
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            iv5 = 1'b1; d5 = 8'h40 + 8'(i); or5 = 1'b1; fl5 = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("steady%0d_count", i), 32'(cnt5), 32'd1);
            check($sformatf("steady%0d_data", i),  32'(od5),  32'(8'h40 + 8'(i)));
        end

        // Reset in the middle of traffic drops everything.
        @(negedge clk);
        iv5 = 1'b1; d5 = 8'h77; or5 = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_count", 32'(cnt5), 32'd2);
        @(negedge clk);
        rst5 = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_count",     32'(cnt5), 32'd0);
        check("mid_rst_out_valid", 32'(ov5),  32'd0);
        check("mid_rst_in_ready",  32'(ir5),  32'd1);
        check("mid_rst_af",        32'(af5),  32'd0);
        check("mid_rst_ae",        32'(ae5),  32'd1);
        @(negedge clk);
        rst5 = 1'b0; iv5 = 1'b0; or5 = 1'b0;

        // Randomized traffic on both random DUTs against queue models.
        rrst = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                sz = mq[k].size();
                check($sformatf("rnd%0d_count", k),     32'(rcnt[k]), 32'(sz));
                check($sformatf("rnd%0d_in_ready", k),  32'(rir[k]),  32'(sz != dep[k]));
                check($sformatf("rnd%0d_out_valid", k), 32'(rov[k]),  32'(sz != 0));
                check($sformatf("rnd%0d_af", k),        32'(raf[k]),  32'(sz >= dep[k] - 2));
                check($sformatf("rnd%0d_ae", k),        32'(rae[k]),  32'(sz <= 2));
                if (sz != 0) begin
                    check($sformatf("rnd%0d_data", k), 32'(rdo[k]), 32'(mq[k][0]));
                end
            end
            rrst = (cyc == 5000) || ($urandom_range(0, 2999) == 0);
            rfl  = ($urandom_range(0, 399) == 0);
            for (int k = 0; k < 2; k++) begin
                if (!hold[k]) begin
                    riv[k] = ($urandom_range(0, 99) < 60);
                    rdi[k] = 8'($urandom);
                end
                rord[k]   = ($urandom_range(0, 99) < (((cyc / 500) % 2 == 0) ? 25 : 85));
                push_m[k] = riv[k] && (mq[k].size() != dep[k]);
                pop_m[k]  = rord[k] && (mq[k].size() != 0);
                hold[k]   = riv[k] && !(push_m[k] && !rrst && !rfl);
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rrst || rfl) begin
                    mq[k].delete();
                end else begin
                    if (pop_m[k]) begin
                        void'(mq[k].pop_front());
                    end
                    if (push_m[k]) begin
                        mq[k].push_back(rdi[k]);
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
